// File: rtl/escalonador_processos_pkg.sv
// Shared definitions for the round-robin process scheduler: default sizes and FSM states.
package escalonador_processos_pkg;

   localparam int unsigned NUM_PROC_DEF = 4;
   localparam int unsigned ID_W_DEF     = 2;
   localparam int unsigned PC_W_DEF     = 32;
   localparam int unsigned Q_W_DEF      = 5;

   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      EXECUTANDO = 3'd1,
      SALVA      = 3'd2,
      SELECIONA  = 3'd3,
      CARREGA    = 3'd4
   } estado_t;

endpackage

// File: rtl/escalonador_processos_seletor.sv
// Combinational rotate-priority finder: first set bit of i_valid at or after i_inicio, wrapping.
module seletor_round_robin
   import escalonador_processos_pkg::*;
#(
   parameter int unsigned N   = NUM_PROC_DEF,
   parameter int unsigned IDW = ID_W_DEF
) (
   input  logic [N-1:0]   i_valid,
   input  logic [IDW-1:0] i_inicio,
   output logic           o_achou,
   output logic [IDW-1:0] o_indice
);

   logic [IDW-1:0] w_pos;

   always_comb begin
      o_achou  = 1'b0;
      o_indice = '0;
      w_pos    = '0;
      // Scan from the far end back toward i_inicio so the closest hit is written last.
      // N is a power of two, so IDW-bit addition wraps modulo N.
      for (int unsigned k = N; k > 0; k--) begin
         w_pos = i_inicio + IDW'(k - 1);
         if (i_valid[w_pos]) begin
            o_achou  = 1'b1;
            o_indice = w_pos;
         end
      end
   end

endmodule

// File: rtl/escalonador_processos.sv
// Preemptive round-robin scheduler: process table, context-switch FSM and creation port.
module escalonador_processos
   import escalonador_processos_pkg::*;
#(
   parameter int unsigned NUM_PROC = NUM_PROC_DEF,
   parameter int unsigned ID_W     = ID_W_DEF,
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned Q_W      = Q_W_DEF
) (
   input  logic            clock,
   input  logic            reset_geral,
   input  logic            modo_preemptivo,
   input  logic            flag_faz_preempcao,
   input  logic [PC_W-1:0] salva_PC,
   input  logic            halt_proc,
   input  logic            cria_valid,
   input  logic [PC_W-1:0] cria_pc,
   input  logic [Q_W-1:0]  cria_quantum,
   output logic            cria_pronto,
   output logic [ID_W-1:0] cria_id,
   output logic            carrega_pc,
   output logic [PC_W-1:0] pc_novo,
   output logic [Q_W-1:0]  quantum,
   output logic            reset_cont_preempcao,
   output logic            troca_contexto,
   output logic [ID_W-1:0] processo_atual,
   output logic            ocioso
);

   estado_t             r_estado, w_prox_estado;
   logic [NUM_PROC-1:0] r_valid;
   logic [PC_W-1:0]     r_tab_pc [NUM_PROC];
   logic [Q_W-1:0]      r_tab_q  [NUM_PROC];
   logic [ID_W-1:0]     r_atual;
   logic [PC_W-1:0]     r_pc_novo;
   logic [Q_W-1:0]      r_quantum;

   logic                w_sel_achou;
   logic [ID_W-1:0]     w_sel_idx;
   logic [ID_W-1:0]     w_sel_inicio;
   logic                w_livre_achou;
   logic [Q_W-1:0]      w_cria_q;
   logic                w_preempta;

   assign w_sel_inicio = r_atual + ID_W'(1);
   assign w_cria_q     = (cria_quantum == '0) ? Q_W'(1) : cria_quantum;
   assign w_preempta   = modo_preemptivo & flag_faz_preempcao;
   assign cria_pronto  = cria_valid & w_livre_achou;

   seletor_round_robin #(.N(NUM_PROC), .IDW(ID_W)) u_sel_proximo (
      .i_valid  (r_valid),
      .i_inicio (w_sel_inicio),
      .o_achou  (w_sel_achou),
      .o_indice (w_sel_idx)
   );

   seletor_round_robin #(.N(NUM_PROC), .IDW(ID_W)) u_sel_livre (
      .i_valid  (~r_valid),
      .i_inicio ('0),
      .o_achou  (w_livre_achou),
      .o_indice (cria_id)
   );

   always_ff @(posedge clock or negedge reset_geral) begin
      if (!reset_geral) r_estado <= OCIOSO;
      else              r_estado <= w_prox_estado;
   end

   always_comb begin
      w_prox_estado = r_estado;
      case (r_estado)
         OCIOSO:     if (|r_valid) w_prox_estado = SELECIONA;
         EXECUTANDO: begin
            if (halt_proc)       w_prox_estado = SELECIONA;
            else if (w_preempta) w_prox_estado = SALVA;
         end
         SALVA:      w_prox_estado = SELECIONA;
         SELECIONA:  w_prox_estado = w_sel_achou ? CARREGA : OCIOSO;
         CARREGA:    w_prox_estado = EXECUTANDO;
         default:    w_prox_estado = OCIOSO;
      endcase
   end

   // Creation never targets the running slot (it is valid), so it cannot collide with halt/save.
   always_ff @(posedge clock or negedge reset_geral) begin
      if (!reset_geral) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < NUM_PROC; i++) begin
            r_tab_pc[i] <= '0;
            r_tab_q[i]  <= '0;
         end
      end else begin
         if (cria_pronto) begin
            r_valid[cria_id]  <= 1'b1;
            r_tab_pc[cria_id] <= cria_pc;
            r_tab_q[cria_id]  <= w_cria_q;
         end
         if (r_estado == EXECUTANDO) begin
            if (halt_proc)       r_valid[r_atual]  <= 1'b0;
            else if (w_preempta) r_tab_pc[r_atual] <= salva_PC;
         end
      end
   end

   // The selected slot is latched straight into the output registers, valid throughout CARREGA.
   always_ff @(posedge clock or negedge reset_geral) begin
      if (!reset_geral) begin
         r_atual   <= '0;
         r_pc_novo <= '0;
         r_quantum <= '0;
      end else if (r_estado == SELECIONA && w_sel_achou) begin
         r_atual   <= w_sel_idx;
         r_pc_novo <= r_tab_pc[w_sel_idx];
         r_quantum <= r_tab_q[w_sel_idx];
      end
   end

   assign carrega_pc           = (r_estado == CARREGA);
   assign troca_contexto       = (r_estado == CARREGA);
   assign reset_cont_preempcao = (r_estado != EXECUTANDO);
   assign ocioso               = (r_estado == OCIOSO);
   assign pc_novo              = r_pc_novo;
   assign quantum              = r_quantum;
   assign processo_atual       = r_atual;

endmodule

// File: tb/tb_escalonador_processos.sv
// Bench for escalonador_processos: directed scenarios plus random traffic against a cycle model.
module tb_escalonador_processos;

   localparam int N = 4;

   logic        clock = 1'b0;
   logic        reset_geral = 1'b0;
   logic        modo_preemptivo = 1'b0;
   logic        flag_faz_preempcao = 1'b0;
   logic [31:0] salva_PC = '0;
   logic        halt_proc = 1'b0;
   logic        cria_valid = 1'b0;
   logic [31:0] cria_pc = '0;
   logic [4:0]  cria_quantum = '0;
   logic        cria_pronto;
   logic [1:0]  cria_id;
   logic        carrega_pc;
   logic [31:0] pc_novo;
   logic [4:0]  quantum;
   logic        reset_cont_preempcao;
   logic        troca_contexto;
   logic [1:0]  processo_atual;
   logic        ocioso;

   int n_testes = 0;
   int n_falhas = 0;

   // Reference: process table plus "where are we in a switch" bookkeeping.
   bit          m_valid [N];
   logic [31:0] m_pc    [N];
   logic [4:0]  m_q     [N];
   bit          m_run, m_idle, m_load;
   int          m_falta;   // cycles left before the selection cycle of a switch (0 = none)
   int          m_atual;
   logic [31:0] m_pc_novo;
   logic [4:0]  m_quantum;

   escalonador_processos #(.NUM_PROC(4), .ID_W(2), .PC_W(32), .Q_W(5)) dut (
      .clock                (clock),
      .reset_geral          (reset_geral),
      .modo_preemptivo      (modo_preemptivo),
      .flag_faz_preempcao   (flag_faz_preempcao),
      .salva_PC             (salva_PC),
      .halt_proc            (halt_proc),
      .cria_valid           (cria_valid),
      .cria_pc              (cria_pc),
      .cria_quantum         (cria_quantum),
      .cria_pronto          (cria_pronto),
      .cria_id              (cria_id),
      .carrega_pc           (carrega_pc),
      .pc_novo              (pc_novo),
      .quantum              (quantum),
      .reset_cont_preempcao (reset_cont_preempcao),
      .troca_contexto       (troca_contexto),
      .processo_atual       (processo_atual),
      .ocioso               (ocioso)
   );

   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_testes++;
      if (obs !== esp) begin
         n_falhas++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   function automatic int primeiro_livre();
      for (int i = 0; i < N; i++)
         if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic modelo_reset();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_run = 1'b0; m_idle = 1'b1; m_load = 1'b0; m_falta = 0;
      m_atual = 0; m_pc_novo = '0; m_quantum = '0;
   endtask

   task automatic confere();
      int livre = primeiro_livre();
      bit pronto = cria_valid && (livre >= 0);
      verifica("ocioso",         32'(ocioso),               32'(m_idle));
      verifica("reset_cont",     32'(reset_cont_preempcao), 32'(!m_run));
      verifica("carrega_pc",     32'(carrega_pc),           32'(m_load));
      verifica("troca_contexto", 32'(troca_contexto),       32'(m_load));
      verifica("processo_atual", 32'(processo_atual),       32'(m_atual));
      verifica("pc_novo",        pc_novo,                   m_pc_novo);
      verifica("quantum",        32'(quantum),              32'(m_quantum));
      verifica("cria_pronto",    32'(cria_pronto),          32'(pronto));
      if (pronto) verifica("cria_id", 32'(cria_id), 32'(livre));
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic modelo_avanca();
      int  livre = primeiro_livre();
      bit  achou = 1'b0;
      bit  algum = 1'b0;
      int  base  = m_atual;
      if (m_run) begin
         if (halt_proc) begin
            m_valid[m_atual] = 1'b0; m_run = 1'b0; m_falta = 1;
         end else if (modo_preemptivo && flag_faz_preempcao) begin
            m_pc[m_atual] = salva_PC; m_run = 1'b0; m_falta = 2;
         end
      end else if (m_load) begin
         m_load = 1'b0; m_run = 1'b1;
      end else if (m_falta == 2) begin
         m_falta = 1;
      end else if (m_falta == 1) begin
         m_falta = 0;
         for (int j = 1; j <= N; j++) begin
            int k = (base + j) % N;
            if (!achou && m_valid[k]) begin
               achou = 1'b1; m_atual = k;
            end
         end
         if (achou) begin
            m_load = 1'b1; m_pc_novo = m_pc[m_atual]; m_quantum = m_q[m_atual];
         end else begin
            m_idle = 1'b1;
         end
      end else if (m_idle) begin
         for (int i = 0; i < N; i++) algum |= m_valid[i];
         if (algum) begin
            m_idle = 1'b0; m_falta = 1;
         end
      end
      if (cria_valid && livre >= 0) begin
         m_valid[livre] = 1'b1;
         m_pc[livre]    = cria_pc;
         m_q[livre]     = (cria_quantum == 5'd0) ? 5'd1 : cria_quantum;
      end
   endtask

   task automatic passo(input bit cv, input logic [31:0] cpc, input logic [4:0] cq,
                        input bit md, input bit fl, input logic [31:0] spc, input bit ht);
      @(negedge clock);
      cria_valid = cv; cria_pc = cpc; cria_quantum = cq;
      modo_preemptivo = md; flag_faz_preempcao = fl; salva_PC = spc; halt_proc = ht;
      #1;
      confere();
      modelo_avanca();
      @(posedge clock);
   endtask

   task automatic ocio(input int n);
      for (int i = 0; i < n; i++) passo(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic cria(input logic [31:0] pc, input logic [4:0] q);
      passo(1'b1, pc, q, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic aplica_reset();
      @(negedge clock);
      reset_geral = 1'b0;
      cria_valid = 1'b0; halt_proc = 1'b0; flag_faz_preempcao = 1'b0;
      #1;
      verifica("rst_ocioso",     32'(ocioso),               32'd1);
      verifica("rst_reset_cont", 32'(reset_cont_preempcao), 32'd1);
      verifica("rst_carrega_pc", 32'(carrega_pc),           32'd0);
      verifica("rst_troca",      32'(troca_contexto),       32'd0);
      verifica("rst_atual",      32'(processo_atual),       32'd0);
      verifica("rst_pc_novo",    pc_novo,                   32'd0);
      verifica("rst_quantum",    32'(quantum),              32'd0);
      modelo_reset();
      @(posedge clock);
      #1;
      reset_geral = 1'b1;
   endtask

   initial begin
      modelo_reset();
      aplica_reset();

      // Single process start-up, then a second process and two preemptions.
      cria(32'h10, 5'd4);
      ocio(4);
      cria(32'h40, 5'd6);
      ocio(2);
      passo(1'b0, '0, '0, 1'b1, 1'b1, 32'h17, 1'b0);
      ocio(5);
      passo(1'b0, '0, '0, 1'b1, 1'b1, 32'h45, 1'b0);
      ocio(5);

      // Single process re-selected after preemption.
      aplica_reset();
      cria(32'h30, 5'd0);
      ocio(4);
      passo(1'b0, '0, '0, 1'b1, 1'b1, 32'h22, 1'b0);
      ocio(5);

      // Halt and preemption together, then halt down to idle.
      aplica_reset();
      cria(32'h10, 5'd3);
      cria(32'h20, 5'd5);
      cria(32'h30, 5'd7);
      ocio(3);
      passo(1'b0, '0, '0, 1'b1, 1'b1, 32'h99, 1'b1);
      ocio(4);
      for (int i = 0; i < 3; i++) begin
         passo(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
         ocio(3);
      end

      // Table full, then a freed slot becomes available to creation.
      aplica_reset();
      for (int i = 0; i < 5; i++) cria(32'h100 + 32'(i), 5'(i + 1));
      ocio(4);
      passo(1'b1, 32'h500, 5'd9, 1'b1, 1'b0, '0, 1'b1);
      passo(1'b1, 32'h500, 5'd9, 1'b1, 1'b0, '0, 1'b0);
      ocio(4);

      // Preemption disabled: flag pulses must not move the running process.
      for (int i = 0; i < 8; i++) passo(1'b0, '0, '0, 1'b0, 1'(i % 2), 32'h77, 1'b0);

      // Reset landing during the save cycle.
      passo(1'b0, '0, '0, 1'b1, 1'b1, 32'h55, 1'b0);
      aplica_reset();
      passo(1'b1, 32'h600, 5'd2, 1'b1, 1'b0, '0, 1'b0);
      ocio(4);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 599) == 0) aplica_reset();
         else passo($urandom_range(0, 3) == 0, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom,
                    $urandom_range(0, 11) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
      $finish;
   end

endmodule
